// File: rtl/instr_sequencer_pkg.sv
// Shared ISA definitions for the instruction sequencer: IR field positions, control-flow opcodes, FSM states.
// SEQ_SINGLE_STEP_EN adds the STEP_WAIT state.
package isa_pkg;

  localparam int OPER_MSB  = 31;
  localparam int OPER_LSB  = 27;
  localparam int RDST_MSB  = 26;
  localparam int RDST_LSB  = 22;
  localparam int RSRC1_MSB = 21;
  localparam int RSRC1_LSB = 17;
  localparam int MODE_BIT  = 16;
  localparam int RSRC2_MSB = 15;
  localparam int RSRC2_LSB = 11;
  localparam int ISRC_MSB  = 15;
  localparam int ISRC_LSB  = 0;

  localparam logic [4:0] OP_JMP  = 5'd12;
  localparam logic [4:0] OP_JZ   = 5'd13;
  localparam logic [4:0] OP_HALT = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED,
    S_ERROR
`ifdef SEQ_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } seq_state_t;

  function automatic logic [4:0] oper_type(input logic [31:0] ir);
    return ir[OPER_MSB:OPER_LSB];
  endfunction

  function automatic logic [4:0] rdst(input logic [31:0] ir);
    return ir[RDST_MSB:RDST_LSB];
  endfunction

  function automatic logic [4:0] rsrc1(input logic [31:0] ir);
    return ir[RSRC1_MSB:RSRC1_LSB];
  endfunction

  function automatic logic mode(input logic [31:0] ir);
    return ir[MODE_BIT];
  endfunction

  function automatic logic [4:0] rsrc2(input logic [31:0] ir);
    return ir[RSRC2_MSB:RSRC2_LSB];
  endfunction

  function automatic logic [15:0] isrc(input logic [31:0] ir);
    return ir[ISRC_MSB:ISRC_LSB];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory and datapath handshake bundle between the sequencer (master) and memory/ALU (slave).
interface instr_sequencer_if #(
  parameter int ADDR_W = 16
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_valid;
  logic [31:0]       ir;
  logic              ir_load;
  logic              exec_en;
  logic              exec_done;
  logic              flag_zero;

  modport master (
    output imem_req, imem_addr, ir, ir_load, exec_en,
    input  imem_rdata, imem_valid, exec_done, flag_zero
  );

  modport slave (
    input  imem_req, imem_addr, ir, ir_load, exec_en,
    output imem_rdata, imem_valid, exec_done, flag_zero
  );

endinterface

// File: rtl/instr_sequencer_watchdog.sv
// EXEC-phase watchdog: cleared on entry to EXEC, counts stalled cycles, flags the WDOG_CYCLES-th one.
module seq_watchdog #(
  parameter int WDOG_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Expiry is flagged during the stalled cycle that brings the count to WDOG_CYCLES.
  assign expire = count_en && (cnt_q == CW'(WDOG_CYCLES - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: owns the PC and IR, resolves JMP/JZ/HALT, hands other ops to the datapath.
// Optional SEQ_SINGLE_STEP_EN inserts a STEP_WAIT pause after each completed instruction.
module instr_sequencer
  import isa_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  instr_sequencer_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              ir_load;
  logic              wd_clear, wd_count, wd_expire;
  logic [15:0]       target;

`ifdef SEQ_SINGLE_STEP_EN
  localparam seq_state_t RESUME = S_STEP_WAIT;
  logic step_q;
  logic step_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign step_rise = step && !step_q;
`else
  localparam seq_state_t RESUME = S_FETCH;
`endif

  seq_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .count_en(wd_count),
    .expire  (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ir_load  = 1'b0;
    wd_clear = 1'b0;
    wd_count = 1'b0;
    target   = isrc(ir_q);

    case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (bus.imem_valid) begin
          ir_d    = bus.imem_rdata;
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (oper_type(ir_q))
          OP_HALT: state_d = S_HALTED;
          OP_JMP: begin
            pc_d    = target[ADDR_W-1:0];
            state_d = RESUME;
          end
          OP_JZ: begin
            pc_d    = bus.flag_zero ? target[ADDR_W-1:0] : pc_q + ADDR_W'(1);
            state_d = RESUME;
          end
          default: begin
            wd_clear = 1'b1;
            state_d  = S_EXEC;
          end
        endcase
      end

      S_EXEC: begin
        if (bus.exec_done) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = RESUME;
        end else begin
          wd_count = 1'b1;
          if (wd_expire) state_d = S_ERROR;
        end
      end

`ifdef SEQ_SINGLE_STEP_EN
      S_STEP_WAIT: begin
        if (step_rise) state_d = S_FETCH;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imem_req  = (state_q == S_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.ir        = ir_q;
  assign bus.ir_load   = ir_load;
  assign bus.exec_en   = (state_q == S_EXEC);

  assign pc     = pc_q;
  assign busy   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted = (state_q == S_HALTED);
  assign err    = (state_q == S_ERROR);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: instruction-level program model predicts every cycle's outputs.
module tb_instr_sequencer;

  localparam int WD = 64;

  typedef struct packed {
    logic        req;
    logic [15:0] addr;
    logic        ld;
    logic [31:0] ir;
    logic        en;
    logic [15:0] pc;
    logic        busy;
    logic        halted;
    logic        err;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        start;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step;
`endif
  logic [15:0] pc;
  logic        busy, halted, err;

  instr_sequencer_if #(.ADDR_W(16)) bus ();

  instr_sequencer #(
    .ADDR_W(16),
    .WDOG_CYCLES(WD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SEQ_SINGLE_STEP_EN
    .step  (step),
`endif
    .bus   (bus.master),
    .pc    (pc),
    .busy  (busy),
    .halted(halted),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_on = 0;
  bit          aligned = 0;
  obs_t        exp_v;
  string       cur_tag = "reset";

  // architectural model state
  logic [15:0] m_pc = '0;
  logic [31:0] m_ir = '0;
  bit          m_halted = 0;
  bit          m_err = 0;
  logic [31:0] prog [int];

  always @(negedge clk) begin
    obs_t act;
    if (chk_on) begin
      act = '{bus.imem_req, bus.imem_addr, bus.ir_load, bus.ir, bus.exec_en, pc, busy, halted, err};
      vectors++;
      if (act !== exp_v) begin
        miscompares++;
        $display("FAIL %s t=%0t got req=%b addr=%h ld=%b ir=%h en=%b pc=%h busy=%b halt=%b err=%b want req=%b addr=%h ld=%b ir=%h en=%b pc=%h busy=%b halt=%b err=%b",
                 cur_tag, $time, act.req, act.addr, act.ld, act.ir, act.en, act.pc, act.busy, act.halted, act.err,
                 exp_v.req, exp_v.addr, exp_v.ld, exp_v.ir, exp_v.en, exp_v.pc, exp_v.busy, exp_v.halted, exp_v.err);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic next_cycle();
    if (!aligned) begin
      @(posedge clk);
      #1;
    end
    aligned = 0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
    aligned = 1;
  endtask

  task automatic set_exp(input string tag, input logic req, input logic ld, input logic en, input logic bsy);
    cur_tag = tag;
    exp_v   = '{req, m_pc, ld, m_ir, en, m_pc, bsy, logic'(m_halted), logic'(m_err)};
  endtask

  task automatic drive(input logic st, input logic vld, input logic [31:0] rd, input logic dn, input logic fz);
    start          = st;
    bus.imem_valid = vld;
    bus.imem_rdata = rd;
    bus.exec_done  = dn;
    bus.flag_zero  = fz;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      drive(1'b0, 1'b1, 32'h1000_0000, 1'b1, 1'b0);
      set_exp(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_start(input string tag);
    next_cycle();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    set_exp(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    m_pc     = '0;
    m_halted = 0;
    m_err    = 0;
  endtask

  task automatic step_pause(input string tag);
`ifdef SEQ_SINGLE_STEP_EN
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(i < 2, 1'b1, 32'h1000_0000, 1'b1, 1'b1);
      step = (i == 2);
      set_exp(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    end
`else
    cur_tag = tag;
`endif
  endtask

  // One instruction: mem_wait stalled FETCH cycles, DECODE, then EXEC with exec_wait stalled cycles.
  task automatic run_instr(input int mem_wait, input int exec_wait, input logic flag, input string tag);
    logic [31:0] w;
    logic [4:0]  op;
    bit          done;
    w = prog.exists(int'(m_pc)) ? prog[int'(m_pc)] : 32'h0;
    for (int k = 0; k <= mem_wait; k++) begin
      next_cycle();
      drive(k == 0, k == mem_wait, (k == mem_wait) ? w : 32'hF800_0000, 1'b1, ~flag);
`ifdef SEQ_SINGLE_STEP_EN
      step = 1'b0;
`endif
      set_exp(tag, 1'b1, k == mem_wait, 1'b0, 1'b1);
    end
    m_ir = w;
    next_cycle();
    drive(1'b1, 1'b1, 32'h6000_0099, 1'b1, flag);
    set_exp(tag, 1'b0, 1'b0, 1'b0, 1'b1);
    op = w[31:27];
    if (op == 5'd31) begin
      m_halted = 1;
    end else if (op == 5'd12) begin
      m_pc = w[15:0];
      step_pause(tag);
    end else if (op == 5'd13) begin
      m_pc = flag ? w[15:0] : m_pc + 16'd1;
      step_pause(tag);
    end else begin
      done = 0;
      for (int k = 0; k < WD && !done; k++) begin
        next_cycle();
        drive(1'b1, 1'b1, 32'hF800_0000, k == exec_wait, ~flag);
        set_exp(tag, 1'b0, 1'b0, 1'b1, 1'b1);
        done = (k == exec_wait);
      end
      if (done) begin
        m_pc = m_pc + 16'd1;
        step_pause(tag);
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic reset_mid_fetch();
    next_cycle();
    drive(1'b0, 1'b0, 32'hF800_0000, 1'b0, 1'b0);
    set_exp("rst_fetch", 1'b1, 1'b0, 1'b0, 1'b1);
    m_pc = '0; m_ir = '0; m_halted = 0; m_err = 0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      rst_n = (i == 2);
      drive(1'b0, 1'b1, 32'hF800_0000, 1'b0, 1'b0);
      set_exp("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    set_exp("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_on = 1;

    prog[32'h0000] = 32'h1000_0000;  // ADD
    prog[32'h0001] = 32'h6000_0003;  // JMP 3
    prog[32'h0003] = 32'h6000_0040;  // JMP 0x40
    prog[32'h0040] = 32'h6800_0010;  // JZ 0x10
    prog[32'h0010] = 32'h6800_0010;  // JZ 0x10
    prog[32'h0011] = 32'h2800_0811;  // ALU op 5
    prog[32'h0012] = 32'h6000_0005;  // JMP 5
    prog[32'h0005] = 32'hF800_0000;  // HALT
    prog[32'hFFFF] = 32'h0800_0000;  // ALU op 1

    next_cycle();
    rst_n = 1'b1;
    set_exp("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    do_start("start");
    run_instr(1, 0, 1'b0, "add");
    after_edge();
    lit("add_pc", 32'(pc), 32'h1);
    run_instr(1, 0, 1'b0, "jmp3");
    run_instr(1, 0, 1'b0, "jmp40");
    after_edge();
    lit("jmp_addr", 32'(bus.imem_addr), 32'h40);
    run_instr(1, 0, 1'b1, "jz_taken");
    after_edge();
    lit("jz_taken_pc", 32'(pc), 32'h10);
    run_instr(1, 0, 1'b0, "jz_fall");
    after_edge();
    lit("jz_fall_pc", 32'(pc), 32'h11);
    run_instr(2, 3, 1'b0, "alu_slow");
    run_instr(0, 0, 1'b1, "jmp5");
    run_instr(1, 0, 1'b0, "halt");
    after_edge();
    lit("halt_flag", 32'(halted), 32'h1);
    lit("halt_pc", 32'(pc), 32'h5);
    idle(3, "halted");

    do_start("restart");
    prog[32'h0000] = 32'h3800_1234;
    run_instr(1, 100, 1'b0, "wdog");
    after_edge();
    lit("wdog_err", 32'(err), 32'h1);
    lit("wdog_en", 32'(bus.exec_en), 32'h0);
    idle(2, "error");

    do_start("restart2");
    prog[32'h0000] = 32'h6000_FFFF;
    run_instr(1, 0, 1'b0, "jmp_top");
    run_instr(1, 1, 1'b0, "wrap");
    after_edge();
    lit("wrap_pc", 32'(pc), 32'h0);

    reset_mid_fetch();
    do_start("restart3");
    prog[32'h0000] = 32'h1000_0000;
    run_instr(1, 0, 1'b0, "add2");
    after_edge();
    chk_on = 0;
    lit("add2_pc", 32'(pc), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/decode/execute controller for the 32-bit instruction-set processor. It owns the program counter, fetches instruction words from instruction memory through a request/valid handshake, and loads them into the IR. It resolves control-flow opcodes itself and hands every other instruction to the IR+ALU datapath through an enable/done handshake. A watchdog traps a datapath that never completes.

## Interface
- `ADDR_W`, default 16: PC and instruction-address width.
- `WDOG_CYCLES`, default 64: maximum number of EXEC cycles allowed without `exec_done`.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin execution at address 0; honoured only in IDLE, HALTED or ERROR.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out ADDR_W: fetch address; always equals `pc`.
- `imem_rdata` in 32: instruction word; sampled when `imem_valid` is high.
- `imem_valid` in 1: read data valid.
- `ir` out 32: instruction register.
- `ir_load` out 1: one-cycle pulse in the cycle `ir` updates.
- `exec_en` out 1: datapath execute request; held high until `exec_done`.
- `exec_done` in 1: datapath completion; may rise in the first `exec_en` cycle.
- `flag_zero` in 1: datapath zero flag, used by JZ.
- `pc` out ADDR_W: program counter.
- `busy` out 1: high in FETCH, DECODE and EXEC.
- `halted` out 1: high in HALTED.
- `err` out 1: high in ERROR (watchdog expiry).
- `step` in 1: single-step advance; present only with `SEQ_SINGLE_STEP_EN`.

## Operation
- IR fields:
  - `oper_type` = IR[31:27]
  - `rdst` = IR[26:22]
  - `rsrc1` = IR[21:17]
  - `mode` = IR[16]
  - `rsrc2` = IR[15:11]
  - `isrc` = IR[15:0]
- Reset values: state IDLE, `pc`=0, `ir`=0, all single-bit outputs 0, watchdog count 0.
- IDLE: on `start`, set `pc`←0 and go to FETCH.
- FETCH:
  - `imem_req`=1.
  - On `imem_valid`: `ir`←`imem_rdata`, `ir_load`=1, go to DECODE.
  - If `imem_valid` is low, stay in FETCH indefinitely.
- DECODE (exactly one cycle, decodes `ir`):
  - OP_HALT: go to HALTED; `pc` unchanged.
  - OP_JMP: `pc`←`isrc`[ADDR_W-1:0], go to FETCH.
  - OP_JZ: `pc`←`flag_zero` ? `isrc`[ADDR_W-1:0] : `pc`+1, go to FETCH.
  - Any other opcode: go to EXEC and clear the watchdog.
- EXEC:
  - `exec_en`=1.
  - On `exec_done`: `pc`←`pc`+1, go to FETCH.
  - Otherwise the watchdog increments; when it reaches `WDOG_CYCLES` go to ERROR with `exec_en` dropped.
- HALTED and ERROR: `start` restarts exactly as from IDLE and clears `halted`/`err`.
- PC arithmetic is modulo 2^ADDR_W: `pc`+1 from all-ones wraps to 0 silently.
- `start` while `busy` is ignored.
- `exec_done` outside EXEC is ignored.
- `imem_valid` outside FETCH is ignored.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous); a pending fetch is abandoned.

## Timing
- `ir_load` and the `ir` update happen in the `imem_valid` cycle; `ir` is stable from the next cycle.
- Best-case ALU instruction, with `imem_valid` one cycle after `imem_req` and `exec_done` in the first EXEC cycle: 4 cycles (FETCH ×2, DECODE, EXEC).
- Jump or branch: 3 cycles (FETCH ×2, DECODE).
- `flag_zero` is sampled in the DECODE cycle.
- `pc` changes on the clock edge leaving DECODE or EXEC; `imem_addr` follows combinationally.
- ERROR is entered on the edge after the `WDOG_CYCLES`-th EXEC cycle without `exec_done`.

## Configuration
- `SEQ_SINGLE_STEP_EN` defined:
  - Adds the `step` input.
  - After each EXEC completion or jump resolution, the FSM waits in a STEP_WAIT state (`busy`=0) until a `step` rising edge, then goes to FETCH.
  - `start` in STEP_WAIT is ignored.
- Undefined: no `step` port, no STEP_WAIT state; execution is free-running.

## Structure
- Shared package `isa_pkg`:
  - field bit positions
  - `OP_JMP`=5'd12, `OP_JZ`=5'd13, `OP_HALT`=5'd31
  - state enumeration
- Optional sub-module `seq_watchdog`: load/clear/count/expire counter sized by `WDOG_CYCLES`. Everything else lives in one FSM module.

## Test plan
- Reset, then `start`, memory returning ADD (oper_type 2) at address 0 and `exec_done` in the first EXEC cycle → `ir_load` at cycle 2, `exec_en` for 1 cycle, `pc`=1 after 4 cycles.
- JMP with `isrc`=0x0040 at `pc`=3 → next `imem_addr`=0x0040, `exec_en` never asserted.
- JZ with `isrc`=0x0010:
  - `flag_zero`=1 → `pc`=0x0010
  - `flag_zero`=0 → `pc`=`pc`+1
- HALT at `pc`=5 → `halted`=1, `pc`=5; a later `start` → `pc`=0, FETCH.
- `exec_done` withheld for 64 cycles → `err`=1 and `exec_en`=0; `rst_n` low mid-FETCH → all outputs return to 0 at once.
- `pc`=0xFFFF, ALU op completes → `pc`=0x0000; with the macro defined, no fetch occurs until a `step` pulse.
